// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the MEM-stage data-cache access sequencer.
package mem_ctrl_pkg;

   localparam int DEFAULT_DATA_W = 32;

   localparam logic [3:0] WSTRB_WORD  = 4'b1111;
   localparam logic [3:0] WSTRB_BYTE0 = 4'b0001;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } state_e;

   // Byte-lane enable for a single byte store at the given offset.
   function automatic logic [3:0] byte_strb(input logic [1:0] off);
      return WSTRB_BYTE0 << off;
   endfunction

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Data-cache request/response bus between the MEM-stage controller and the cache.
interface mem_stage_ctrl_if #(
   parameter int DATA_W = 32,
   parameter int STRB_W = DATA_W / 8
);
   logic              dc_req;
   logic              dc_we;
   logic [DATA_W-1:0] dc_addr;
   logic [DATA_W-1:0] dc_wdata;
   logic [STRB_W-1:0] dc_wstrb;
   logic              dc_req_ready;
   logic              dc_resp_valid;
   logic [DATA_W-1:0] dc_rdata;

   modport master (
      output dc_req, dc_we, dc_addr, dc_wdata, dc_wstrb,
      input  dc_req_ready, dc_resp_valid, dc_rdata
   );

   modport slave (
      input  dc_req, dc_we, dc_addr, dc_wdata, dc_wstrb,
      output dc_req_ready, dc_resp_valid, dc_rdata
   );
endinterface

// File: rtl/mem_load_align.sv
// Load alignment: passes words through, selects and sign-extends bytes by offset.
module mem_load_align
   import mem_ctrl_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W
) (
   input  logic              word_i,
   input  logic [1:0]        off_i,
   input  logic [DATA_W-1:0] rdata_i,
   output logic [DATA_W-1:0] data_o
);

   logic [7:0] byte_s;

   // Byte lane select followed by sign extension.
   always_comb begin
      byte_s = 8'h00;
      case (off_i)
         2'd0:    byte_s = rdata_i[7:0];
         2'd1:    byte_s = rdata_i[15:8];
         2'd2:    byte_s = rdata_i[23:16];
         2'd3:    byte_s = rdata_i[31:24];
         default: byte_s = 8'h00;
      endcase
      if (word_i) begin
         data_o = rdata_i;
      end else begin
         data_o = {{(DATA_W-8){byte_s[7]}}, byte_s};
      end
   end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage data-cache access sequencer: one request per load/store, pipeline stall,
// byte-load alignment and store strobes. Define MEM_CTRL_PERF_EN for perf counters.
module mem_stage_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter int STRB_W = DATA_W / 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_read_i,
   input  logic              mem_write_i,
   input  logic              ls_word_i,
   input  logic [DATA_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              pipe_hold_i,
   mem_stage_ctrl_if.master  dc,
   output logic              stall_o,
   output logic [DATA_W-1:0] load_data_o,
   output logic              load_valid_o
`ifdef MEM_CTRL_PERF_EN
   ,
   output logic [31:0]       stall_cycles_o,
   output logic [31:0]       access_cnt_o
`endif
);

   state_e            state_q, state_d;
   logic              access_s, capture_s, handshake_s, complete_s, stall_s;
   logic              req_q, we_q, read_q, word_q;
   logic [1:0]        off_q;
   logic [DATA_W-1:0] addr_q, wdata_q, load_data_q, aligned_s;
   logic [STRB_W-1:0] wstrb_q;
   logic              load_valid_q;

   assign access_s = mem_read_i | mem_write_i;

   // Next-state and per-cycle control decode.
   always_comb begin
      state_d     = state_q;
      capture_s   = 1'b0;
      handshake_s = 1'b0;
      complete_s  = 1'b0;
      stall_s     = 1'b0;
      case (state_q)
         IDLE: begin
            if (access_s) begin
               capture_s = 1'b1;
               stall_s   = 1'b1;
               state_d   = REQ;
            end else begin
               state_d   = IDLE;
            end
         end
         REQ: begin
            stall_s = 1'b1;
            if (dc.dc_req_ready) begin
               handshake_s = 1'b1;
               if (dc.dc_resp_valid) begin
                  complete_s = 1'b1;
                  state_d    = DONE;
               end else begin
                  state_d    = WAIT;
               end
            end else begin
               state_d = REQ;
            end
         end
         WAIT: begin
            stall_s = 1'b1;
            if (dc.dc_resp_valid) begin
               complete_s = 1'b1;
               state_d    = DONE;
            end else begin
               state_d    = WAIT;
            end
         end
         DONE: begin
            if (pipe_hold_i) begin
               state_d = DONE;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Request registers: captured once per access, held until the cache accepts.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         read_q  <= 1'b0;
         word_q  <= 1'b0;
         off_q   <= 2'd0;
         addr_q  <= {DATA_W{1'b0}};
         wdata_q <= {DATA_W{1'b0}};
         wstrb_q <= {STRB_W{1'b0}};
      end else if (capture_s) begin
         req_q   <= 1'b1;
         we_q    <= mem_write_i & ~mem_read_i;
         read_q  <= mem_read_i;
         word_q  <= ls_word_i;
         off_q   <= addr_i[1:0];
         addr_q  <= ls_word_i ? {addr_i[DATA_W-1:2], 2'b00} : addr_i;
         wdata_q <= ls_word_i ? wdata_i : {STRB_W{wdata_i[7:0]}};
         wstrb_q <= ls_word_i ? STRB_W'(WSTRB_WORD) : STRB_W'(byte_strb(addr_i[1:0]));
      end else if (handshake_s) begin
         req_q   <= 1'b0;
      end
   end

   mem_load_align #(.DATA_W(DATA_W)) u_align (
      .word_i  (word_q),
      .off_i   (off_q),
      .rdata_i (dc.dc_rdata),
      .data_o  (aligned_s)
   );

   // Load result: valid for the whole DONE residency, data held until the next read.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         load_data_q  <= {DATA_W{1'b0}};
         load_valid_q <= 1'b0;
      end else begin
         load_valid_q <= read_q & (state_d == DONE);
         if (complete_s && read_q) begin
            load_data_q <= aligned_s;
         end
      end
   end

`ifdef MEM_CTRL_PERF_EN
   logic [31:0] stall_cycles_q, access_cnt_q;

   // Saturating performance counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cycles_q <= 32'd0;
         access_cnt_q   <= 32'd0;
      end else begin
         if (stall_s && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_q <= stall_cycles_q + 32'd1;
         end
         if (handshake_s && (access_cnt_q != 32'hFFFF_FFFF)) begin
            access_cnt_q <= access_cnt_q + 32'd1;
         end
      end
   end

   assign stall_cycles_o = stall_cycles_q;
   assign access_cnt_o   = access_cnt_q;
`endif

   assign dc.dc_req     = req_q;
   assign dc.dc_we      = we_q;
   assign dc.dc_addr    = addr_q;
   assign dc.dc_wdata   = wdata_q;
   assign dc.dc_wstrb   = wstrb_q;
   assign stall_o       = stall_s;
   assign load_data_o   = load_data_q;
   assign load_valid_o  = load_valid_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: per-transaction timeline model plus literal pins.
module tb_mem_stage_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_read, mem_write, ls_word, pipe_hold;
   logic [31:0] addr, wdata;
   logic        stall;
   logic [31:0] load_data;
   logic        load_valid;

   always #5 clk = ~clk;

   mem_stage_ctrl_if #(.DATA_W(32)) dc ();

`ifdef MEM_CTRL_PERF_EN
   logic [31:0] stall_cycles, access_cnt;
`endif

   mem_stage_ctrl #(.DATA_W(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .mem_read_i   (mem_read),
      .mem_write_i  (mem_write),
      .ls_word_i    (ls_word),
      .addr_i       (addr),
      .wdata_i      (wdata),
      .pipe_hold_i  (pipe_hold),
      .dc           (dc),
      .stall_o      (stall),
      .load_data_o  (load_data),
      .load_valid_o (load_valid)
`ifdef MEM_CTRL_PERF_EN
      ,
      .stall_cycles_o (stall_cycles),
      .access_cnt_o   (access_cnt)
`endif
   );

   // Expected outputs for the current cycle, set by the stimulus process.
   logic        exp_stall, exp_req, exp_lv, exp_we, chk_fields, chk_en;
   logic [31:0] exp_addr, exp_wdata, exp_ld, model_ld;
   logic [3:0]  exp_strb;
   logic [31:0] seen_addr, seen_wdata;
   logic [3:0]  seen_strb;
   logic        seen_we;
   int          n_checks = 0;
   int          n_fail = 0;
   int          stall_seen = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("stall_o", {31'd0, stall}, {31'd0, exp_stall});
         chk("dc_req_o", {31'd0, dc.dc_req}, {31'd0, exp_req});
         chk("load_valid_o", {31'd0, load_valid}, {31'd0, exp_lv});
         chk("load_data_o", load_data, exp_ld);
         if (chk_fields) begin
            chk("dc_addr_o", dc.dc_addr, exp_addr);
            chk("dc_we_o", {31'd0, dc.dc_we}, {31'd0, exp_we});
            chk("dc_wstrb_o", {28'd0, dc.dc_wstrb}, {28'd0, exp_strb});
            chk("dc_wdata_o", dc.dc_wdata, exp_wdata);
         end
         if (stall === 1'b1) stall_seen++;
      end
   end

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk); #1;
         mem_read = 1'b0; mem_write = 1'b0; ls_word = 1'b0; pipe_hold = 1'b0;
         addr = 32'd0; wdata = 32'd0;
         dc.dc_req_ready = 1'b0; dc.dc_resp_valid = 1'b0; dc.dc_rdata = $urandom;
         exp_stall = 1'b0; exp_req = 1'b0; exp_lv = 1'b0; chk_fields = 1'b0;
         exp_ld = model_ld;
      end
   endtask

   // One access: the cache accepts after rdy extra REQ cycles, answers rsp cycles
   // after acceptance, and the pipeline holds DONE for hold extra cycles.
   task automatic run_txn(input logic rd, input logic wr, input logic word,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                          input int rdy, input int rsp, input int hold);
      logic [31:0] e_load, b;
      logic [3:0]  one;
      int          done_at, n;
      one       = 4'b0001;
      exp_addr  = word ? {a[31:2], 2'b00} : a;
      exp_strb  = word ? 4'b1111 : (one << a[1:0]);
      exp_wdata = word ? wd : {4{wd[7:0]}};
      exp_we    = wr & ~rd;
      b         = (rdat >> (8 * a[1:0])) & 32'h0000_00FF;
      e_load    = word ? rdat : ((b >= 32'h0000_0080) ? (b | 32'hFFFF_FF00) : b);
      done_at   = rdy + 2 + rsp;
      n         = done_at + 1 + hold;
      stall_seen = 0;
      for (int k = 0; k < n; k++) begin
         @(posedge clk); #1;
         mem_read = rd; mem_write = wr; ls_word = word; addr = a; wdata = wd;
         dc.dc_req_ready  = (k == rdy + 1);
         dc.dc_resp_valid = (k == rdy + 1 + rsp);
         dc.dc_rdata      = (k == rdy + 1 + rsp) ? rdat : $urandom;
         pipe_hold        = (k >= done_at) && (k < n - 1);
         exp_stall  = (k < done_at);
         exp_req    = (k >= 1) && (k <= rdy + 1);
         chk_fields = exp_req;
         if (rd && (k == done_at)) model_ld = e_load;
         exp_lv = rd && (k >= done_at);
         exp_ld = model_ld;
         if (k == 1) begin
            seen_addr = dc.dc_addr; seen_wdata = dc.dc_wdata;
            seen_strb = dc.dc_wstrb; seen_we = dc.dc_we;
         end
      end
      @(negedge clk); #1;
   endtask

   initial begin
      rst = 1'b1;
      mem_read = 1'b0; mem_write = 1'b0; ls_word = 1'b0; pipe_hold = 1'b0;
      addr = 32'd0; wdata = 32'd0;
      dc.dc_req_ready = 1'b0; dc.dc_resp_valid = 1'b0; dc.dc_rdata = 32'd0;
      exp_stall = 1'b0; exp_req = 1'b0; exp_lv = 1'b0; exp_ld = 32'd0; model_ld = 32'd0;
      exp_addr = 32'd0; exp_wdata = 32'd0; exp_strb = 4'd0; exp_we = 1'b0;
      chk_fields = 1'b1; chk_en = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      idle(2);

      // Word load, ready at once, response two cycles after acceptance.
      run_txn(1'b1, 1'b0, 1'b1, 32'h0000_0104, 32'd0, 32'hDEAD_BEEF, 0, 2, 0);
      chk("word_load_stall_cycles", stall_seen, 32'd4);
      chk("word_load_data", load_data, 32'hDEAD_BEEF);
      chk("word_load_valid", {31'd0, load_valid}, 32'd1);
      chk("word_load_addr", seen_addr, 32'h0000_0104);
      idle(1);

      // Byte store to lane 3.
      run_txn(1'b0, 1'b1, 1'b0, 32'h0000_0203, 32'h0000_00A5, 32'h1111_1111, 0, 0, 0);
      chk("byte_store_addr", seen_addr, 32'h0000_0203);
      chk("byte_store_strb", {28'd0, seen_strb}, 32'h0000_0008);
      chk("byte_store_wdata", seen_wdata, 32'hA5A5_A5A5);
      chk("byte_store_we", {31'd0, seen_we}, 32'd1);
      idle(1);

      // Negative byte load from lane 1.
      run_txn(1'b1, 1'b0, 1'b0, 32'h0000_0011, 32'd0, 32'h0000_8000, 1, 1, 0);
      chk("byte_load_sign", load_data, 32'hFFFF_FF80);
      idle(1);

      // Ready delayed three cycles.
      run_txn(1'b1, 1'b0, 1'b1, 32'h2000_000A, 32'd0, 32'h1234_5678, 3, 1, 0);
      chk("delayed_ready_stall_cycles", stall_seen, 32'd6);
      chk("delayed_ready_addr", seen_addr, 32'h2000_0008);
      idle(1);

      // Pipeline holds DONE for two extra cycles; positive byte from lane 3.
      run_txn(1'b1, 1'b0, 1'b0, 32'h0000_0033, 32'd0, 32'h7F00_0000, 0, 0, 2);
      chk("hold_byte_load", load_data, 32'h0000_007F);

      // Back-to-back: read and write together (read wins), then a word store.
      run_txn(1'b1, 1'b1, 1'b0, 32'h0000_0402, 32'h0000_00C3, 32'h0055_0000, 0, 1, 0);
      chk("rw_read_wins_we", {31'd0, seen_we}, 32'd0);
      chk("rw_read_wins_data", load_data, 32'h0000_0055);
      run_txn(1'b0, 1'b1, 1'b1, 32'h0000_0FFF, 32'hCAFE_F00D, 32'h0, 2, 0, 1);
      chk("word_store_keeps_load", load_data, 32'h0000_0055);
      chk("word_store_strb", {28'd0, seen_strb}, 32'h0000_000F);

      // Reset while waiting for the response; a late response must be ignored.
      @(posedge clk); #1;
      mem_read = 1'b1; mem_write = 1'b0; ls_word = 1'b1; addr = 32'h0000_0040; wdata = 32'd0;
      exp_stall = 1'b1; exp_req = 1'b0; exp_lv = 1'b0; chk_fields = 1'b0;
      @(posedge clk); #1;
      dc.dc_req_ready = 1'b1;
      exp_req = 1'b1; chk_fields = 1'b1;
      exp_addr = 32'h0000_0040; exp_we = 1'b0; exp_strb = 4'b1111; exp_wdata = 32'd0;
      @(posedge clk); #1;
      dc.dc_req_ready = 1'b0;
      exp_req = 1'b0; chk_fields = 1'b0;
      @(negedge clk); #2;
      rst = 1'b1; mem_read = 1'b0;
      model_ld = 32'd0; exp_ld = 32'd0;
      exp_stall = 1'b0; exp_req = 1'b0; exp_lv = 1'b0;
      exp_addr = 32'd0; exp_we = 1'b0; exp_strb = 4'd0; exp_wdata = 32'd0; chk_fields = 1'b1;
      #1;
      chk("rst_async_req", {31'd0, dc.dc_req}, 32'd0);
      chk("rst_async_addr", dc.dc_addr, 32'd0);
      chk("rst_async_load_data", load_data, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      dc.dc_resp_valid = 1'b1; dc.dc_rdata = 32'h1234_5678;
      @(posedge clk); #1;
      dc.dc_resp_valid = 1'b0;
      @(negedge clk); #1;
      chk("late_resp_ignored", {31'd0, load_valid}, 32'd0);
      idle(1);

      // Normal operation resumes after reset.
      run_txn(1'b1, 1'b0, 1'b0, 32'h0000_0002, 32'd0, 32'h00AB_0000, 0, 0, 0);
      chk("post_reset_byte_load", load_data, 32'hFFFF_FFAB);
      idle(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
